// File: rtl/interrupt_ack_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pic_pkg
//  Description : Shared types, sizes and the rotate helper for the 8259A-style
//                interrupt acknowledge sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package pic_pkg;

    localparam int IR_COUNT = 8;
    localparam int IR_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        WAIT2   = 2'd2
    } state_t;

    // Rotate an 8-bit vector left by amt positions.
    function automatic logic [IR_COUNT-1:0] rot_left8(
        input logic [IR_COUNT-1:0] vec,
        input logic [IR_IDX_W-1:0] amt
    );
        logic [2*IR_COUNT-1:0] dbl;
        dbl = {vec, vec} << amt;
        return dbl[2*IR_COUNT-1:IR_COUNT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/interrupt_ack_sequencer_prio.sv
`default_nettype none
// ============================================================================
//  Module      : rotating_priority_encoder
//  Description : Combinational priority encoder whose highest priority slot is
//                (lowest_pri_i + 1) mod 8, wrapping round.
//  Revision    : 1.0  initial release
// ============================================================================
module rotating_priority_encoder
    import pic_pkg::*;
(
    input  logic [IR_COUNT-1:0] vec_i,
    input  logic [IR_IDX_W-1:0] lowest_pri_i,
    output logic                valid_o,
    output logic [IR_IDX_W-1:0] index_o
);

    logic [IR_COUNT-1:0] w_rot;
    logic [IR_IDX_W-1:0] w_pos;

    // Align the highest-priority slot onto bit 0, then a fixed LSB-first search.
    assign w_rot = rot_left8(vec_i, 3'd7 - lowest_pri_i);

    always_comb begin
        w_pos = '0;
        for (int i = IR_COUNT - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_pos = IR_IDX_W'(i);
            end
        end
    end

    assign valid_o = |w_rot;
    assign index_o = w_pos + lowest_pri_i + 3'd1;

endmodule
`default_nettype wire

// File: rtl/interrupt_ack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_ack_sequencer
//  Description : 8259A-style INT/INTA handshake: priority resolution, ISR
//                update, IRR clear, vector delivery, EOI and rotation.
//  Revision    : 1.0  initial release
// ============================================================================
module interrupt_ack_sequencer
    import pic_pkg::*;
#(
    parameter logic [7:0] VECTOR_BASE = 8'h08,
    parameter int         AUTO_EOI    = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IR_COUNT-1:0] risedBits,
    input  logic                inta,
    input  logic                eoiStrobe,
    input  logic                rotateOnEoi,
    output logic                intReq,
    output logic [IR_IDX_W-1:0] resetIRR,
    output logic                resetIRRValid,
    output logic [IR_COUNT-1:0] isr,
    output logic [7:0]          vectorOut,
    output logic                vectorValid
);

    localparam logic [7:0] C_SPURIOUS_VEC = {VECTOR_BASE[7:3], 3'b111};

    state_t              state_q, state_d;
    logic [IR_COUNT-1:0] isr_q, isr_d;
    logic [IR_IDX_W-1:0] lowest_pri_q, lowest_pri_d;
    logic [IR_IDX_W-1:0] winner_q, winner_d;
    logic                int_req_q, int_req_d;
    logic [IR_IDX_W-1:0] reset_irr_q, reset_irr_d;
    logic                reset_irr_valid_q, reset_irr_valid_d;
    logic [7:0]          vector_q, vector_d;
    logic                vector_valid_q, vector_valid_d;

    logic [IR_COUNT-1:0] w_eligible;
    logic [IR_COUNT-1:0] w_req_masked;
    logic                w_win_valid;
    logic [IR_IDX_W-1:0] w_win_idx;
    logic                w_eoi_valid;
    logic [IR_IDX_W-1:0] w_eoi_idx;
    logic [IR_IDX_W-1:0] w_eoi_rank;
    logic [IR_COUNT-1:0] w_isr_clr;
    logic [IR_COUNT-1:0] w_isr_set;

    rotating_priority_encoder u_eoi_enc (
        .vec_i        (isr_q),
        .lowest_pri_i (lowest_pri_q),
        .valid_o      (w_eoi_valid),
        .index_o      (w_eoi_idx)
    );

    // A request is eligible only if it outranks the highest in-service level.
    always_comb begin
        w_eligible = '0;
        w_eoi_rank = w_eoi_idx - lowest_pri_q - 3'd1;
        for (int i = 0; i < IR_COUNT; i++) begin
            w_eligible[i] = !w_eoi_valid ||
                            ((IR_IDX_W'(i) - lowest_pri_q - 3'd1) < w_eoi_rank);
        end
    end

    assign w_req_masked = risedBits & w_eligible;

    rotating_priority_encoder u_req_enc (
        .vec_i        (w_req_masked),
        .lowest_pri_i (lowest_pri_q),
        .valid_o      (w_win_valid),
        .index_o      (w_win_idx)
    );

    always_comb begin
        state_d           = state_q;
        lowest_pri_d      = lowest_pri_q;
        winner_d          = winner_q;
        reset_irr_d       = reset_irr_q;
        reset_irr_valid_d = 1'b0;
        vector_d          = vector_q;
        vector_valid_d    = 1'b0;
        w_isr_clr         = '0;
        w_isr_set         = '0;

        if (eoiStrobe && w_eoi_valid) begin
            w_isr_clr[w_eoi_idx] = 1'b1;
            if (rotateOnEoi) begin
                lowest_pri_d = w_eoi_idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (inta) begin
                    vector_d       = C_SPURIOUS_VEC;
                    vector_valid_d = 1'b1;
                end
                if (w_win_valid) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (inta) begin
                    if (w_win_valid) begin
                        w_isr_set[w_win_idx] = 1'b1;
                        reset_irr_d          = w_win_idx;
                        reset_irr_valid_d    = 1'b1;
                        winner_d             = w_win_idx;
                        state_d              = WAIT2;
                    end else begin
                        vector_d       = C_SPURIOUS_VEC;
                        vector_valid_d = 1'b1;
                        state_d        = IDLE;
                    end
                end else if (!w_win_valid) begin
                    state_d = IDLE;
                end
            end
            WAIT2: begin
                if (inta) begin
                    vector_d       = {VECTOR_BASE[7:3], winner_q};
                    vector_valid_d = 1'b1;
                    if (AUTO_EOI != 0) begin
                        w_isr_clr[winner_q] = 1'b1;
                        if (rotateOnEoi) begin
                            lowest_pri_d = winner_q;
                        end
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear first, then set, so an ACK1 set survives a same-cycle EOI.
        isr_d     = (isr_q & ~w_isr_clr) | w_isr_set;
        int_req_d = (state_d == PENDING);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            isr_q             <= '0;
            lowest_pri_q      <= 3'd7;
            winner_q          <= '0;
            int_req_q         <= 1'b0;
            reset_irr_q       <= '0;
            reset_irr_valid_q <= 1'b0;
            vector_q          <= '0;
            vector_valid_q    <= 1'b0;
        end else begin
            state_q           <= state_d;
            isr_q             <= isr_d;
            lowest_pri_q      <= lowest_pri_d;
            winner_q          <= winner_d;
            int_req_q         <= int_req_d;
            reset_irr_q       <= reset_irr_d;
            reset_irr_valid_q <= reset_irr_valid_d;
            vector_q          <= vector_d;
            vector_valid_q    <= vector_valid_d;
        end
    end

    assign intReq        = int_req_q;
    assign resetIRR      = reset_irr_q;
    assign resetIRRValid = reset_irr_valid_q;
    assign isr           = isr_q;
    assign vectorOut     = vector_q;
    assign vectorValid   = vector_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_ack_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_ack_sequencer
//  Description : Directed and randomized bench for interrupt_ack_sequencer
//                (one AUTO_EOI=0 and one AUTO_EOI=1 instance on shared inputs).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_interrupt_ack_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] risedBits = '0;
    logic       inta = 1'b0;
    logic       eoiStrobe = 1'b0;
    logic       rotateOnEoi = 1'b0;

    logic       intReq0, rv0, vv0, intReq1, rv1, vv1;
    logic [2:0] rirr0, rirr1;
    logic [7:0] isr0, vout0, isr1, vout1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    interrupt_ack_sequencer #(.VECTOR_BASE(8'h08), .AUTO_EOI(0)) u_dut0 (
        .clk(clk), .reset(reset), .risedBits(risedBits), .inta(inta),
        .eoiStrobe(eoiStrobe), .rotateOnEoi(rotateOnEoi), .intReq(intReq0),
        .resetIRR(rirr0), .resetIRRValid(rv0), .isr(isr0),
        .vectorOut(vout0), .vectorValid(vv0)
    );

    interrupt_ack_sequencer #(.VECTOR_BASE(8'h08), .AUTO_EOI(1)) u_dut1 (
        .clk(clk), .reset(reset), .risedBits(risedBits), .inta(inta),
        .eoiStrobe(eoiStrobe), .rotateOnEoi(rotateOnEoi), .intReq(intReq1),
        .resetIRR(rirr1), .resetIRRValid(rv1), .isr(isr1),
        .vectorOut(vout1), .vectorValid(vv1)
    );

    // Model phases: 0 idle, 1 request raised, 2 first INTA taken.
    typedef struct packed {
        logic [1:0] ph;
        logic [7:0] isr;
        logic [2:0] lp;
        logic [2:0] w;
        logic       ir;
        logic [2:0] rirr;
        logic       rv;
        logic [7:0] vout;
        logic       vv;
    } mdl_t;

    mdl_t m0, m1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // 0 = highest priority; the slot after lp is served first.
    function automatic int rank(int i, int lp);
        return (i - lp + 15) % 8;
    endfunction

    function automatic int top_bit(logic [7:0] v, int lp);
        int best = -1;
        for (int i = 0; i < 8; i++)
            if (v[i] && (best < 0 || rank(i, lp) < rank(best, lp))) best = i;
        return best;
    endfunction

    function automatic int pick_winner(logic [7:0] req, logic [7:0] isrv, int lp);
        int t = top_bit(isrv, lp);
        int best = -1;
        for (int i = 0; i < 8; i++)
            if (req[i] && (t < 0 || rank(i, lp) < rank(t, lp)) &&
                (best < 0 || rank(i, lp) < rank(best, lp))) best = i;
        return best;
    endfunction

    function automatic mdl_t step(mdl_t m, logic rst, logic [7:0] req, logic ia,
                                  logic eo, logic rot, bit auto_eoi);
        mdl_t n;
        int lp = int'(m.lp);
        int t  = top_bit(m.isr, lp);
        int wn = pick_winner(req, m.isr, lp);
        logic [7:0] clr = '0;
        logic [7:0] set = '0;
        if (rst) begin
            n = '0;
            n.lp = 3'd7;
            return n;
        end
        n = m;
        n.rv = 1'b0;
        n.vv = 1'b0;
        if (eo && t >= 0) begin
            clr[t] = 1'b1;
            if (rot) n.lp = 3'(t);
        end
        if (m.ph == 2'd0) begin
            if (ia) begin n.vout = 8'h0F; n.vv = 1'b1; end
            if (wn >= 0) n.ph = 2'd1;
        end else if (m.ph == 2'd1) begin
            if (ia && wn >= 0) begin
                set[wn] = 1'b1; n.rirr = 3'(wn); n.rv = 1'b1; n.w = 3'(wn); n.ph = 2'd2;
            end else if (ia) begin
                n.vout = 8'h0F; n.vv = 1'b1; n.ph = 2'd0;
            end else if (wn < 0) begin
                n.ph = 2'd0;
            end
        end else begin
            if (ia) begin
                n.vout = 8'h08 + {5'd0, m.w};
                n.vv = 1'b1;
                if (auto_eoi) begin
                    clr[m.w] = 1'b1;
                    if (rot) n.lp = m.w;
                end
                n.ph = 2'd0;
            end
        end
        n.isr = (m.isr & ~clr) | set;
        n.ir  = (n.ph == 2'd1);
        return n;
    endfunction

    task automatic cmp_dut(input string p, input mdl_t m, input logic ir, input logic [7:0] iv,
                           input logic [2:0] rr, input logic rv, input logic [7:0] vo, input logic vv);
        chk({p, "_intReq"}, 32'(ir), 32'(m.ir));
        chk({p, "_isr"}, 32'(iv), 32'(m.isr));
        chk({p, "_rirrValid"}, 32'(rv), 32'(m.rv));
        chk({p, "_vecValid"}, 32'(vv), 32'(m.vv));
        if (m.rv) chk({p, "_rirr"}, 32'(rr), 32'(m.rirr));
        if (m.vv) chk({p, "_vector"}, 32'(vo), 32'(m.vout));
    endtask

    task automatic tick(input logic rst, input logic [7:0] req, input logic ia,
                        input logic eo, input logic rot);
        reset = rst; risedBits = req; inta = ia; eoiStrobe = eo; rotateOnEoi = rot;
        @(posedge clk);
        m0 = step(m0, rst, req, ia, eo, rot, 1'b0);
        m1 = step(m1, rst, req, ia, eo, rot, 1'b1);
        @(negedge clk);
        cmp_dut("d0", m0, intReq0, isr0, rirr0, rv0, vout0, vv0);
        cmp_dut("d1", m1, intReq1, isr1, rirr1, rv1, vout1, vv1);
    endtask

    initial begin
        @(negedge clk);
        tick(1, 8'h00, 0, 0, 0);
        tick(1, 8'h00, 0, 0, 0);
        chk("rst_intReq", 32'(intReq0), 0);
        chk("rst_isr", 32'(isr0), 0);
        chk("rst_vv", 32'(vv0), 0);
        chk("rst_rv", 32'(rv0), 0);

        // IR2 and IR5 pending: IR2 wins
        tick(0, 8'h24, 0, 0, 0);
        chk("s1_intReq", 32'(intReq0), 1);
        tick(0, 8'h24, 1, 0, 0);
        chk("s1_isr", 32'(isr0), 32'h04);
        chk("s1_rirr", 32'(rirr0), 2);
        chk("s1_rv", 32'(rv0), 1);
        tick(0, 8'h20, 1, 0, 0);
        chk("s1_vec", 32'(vout0), 32'h0A);
        chk("s1_vv", 32'(vv0), 1);

        // IR5 blocked by in-service IR2 until EOI
        repeat (3) tick(0, 8'h20, 0, 0, 0);
        chk("s2_blocked", 32'(intReq0), 0);
        tick(0, 8'h20, 0, 1, 0);
        chk("s2_eoi_isr", 32'(isr0), 0);
        tick(0, 8'h20, 0, 0, 0);
        chk("s2_intReq", 32'(intReq0), 1);
        tick(0, 8'h20, 1, 0, 0);
        tick(0, 8'h00, 1, 0, 0);
        tick(0, 8'h00, 0, 1, 0);

        // rotate on EOI after IR0 makes IR7 outrank IR0
        tick(0, 8'h01, 0, 0, 0);
        tick(0, 8'h01, 1, 0, 0);
        tick(0, 8'h00, 1, 0, 0);
        tick(0, 8'h00, 0, 1, 1);
        tick(0, 8'h81, 0, 0, 0);
        tick(0, 8'h81, 1, 0, 0);
        chk("s3_rirr", 32'(rirr0), 7);
        tick(0, 8'h01, 1, 0, 0);
        chk("s3_vec", 32'(vout0), 32'h0F);
        tick(0, 8'h00, 0, 1, 0);

        // request withdrawn before INTA, then a lone spurious INTA
        tick(0, 8'h08, 0, 0, 0);
        chk("s4_pend", 32'(intReq0), 1);
        tick(0, 8'h00, 0, 0, 0);
        chk("s4_drop", 32'(intReq0), 0);
        tick(0, 8'h00, 1, 0, 0);
        chk("s4_spur_vec", 32'(vout0), 32'h0F);
        chk("s4_spur_vv", 32'(vv0), 1);
        chk("s4_isr", 32'(isr0), 0);

        // automatic EOI instance
        tick(0, 8'h02, 0, 0, 0);
        tick(0, 8'h02, 1, 0, 0);
        tick(0, 8'h00, 1, 0, 0);
        chk("s5_vec", 32'(vout1), 32'h09);
        chk("s5_vv", 32'(vv1), 1);
        chk("s5_isr", 32'(isr1), 0);
        tick(0, 8'h00, 0, 1, 0);

        // reset while waiting for the second INTA
        tick(0, 8'h04, 0, 0, 0);
        tick(0, 8'h04, 1, 0, 0);
        tick(1, 8'h00, 0, 0, 0);
        chk("s6_isr", 32'(isr0), 0);
        chk("s6_intReq", 32'(intReq0), 0);
        tick(0, 8'h00, 1, 0, 0);
        chk("s6_spur", 32'(vout0), 32'h0F);
        tick(0, 8'h00, 0, 0, 0);
        chk("s6_no_vv", 32'(vv0), 0);

        for (int k = 0; k < 1500; k++) begin
            tick(($urandom_range(0, 149) == 0),
                 8'($urandom) & 8'($urandom) & 8'($urandom),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 6) == 0),
                 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
